// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with scancode history and FWFT byte FIFO
// Define PS2_RX_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 4,
   parameter int CODE_BYTES     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      PS2_KBCLK,
   input  logic                      PS2_KBDAT,
   output logic [8*CODE_BYTES-1:0]   code_vector,
   output logic [7:0]                byte_data,
   output logic                      byte_valid,
   input  logic                      byte_ready,
   output logic                      frame_err,
   output logic                      overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FILTER_LEN);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   logic              clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic              filt_q, filt_d;
   logic [FW-1:0]     flt_cnt_q, flt_cnt_d;
   logic              sample_evt;
   logic [1:0]        state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              ones_q, ones_d, par_q, par_d;
   logic [7:0]        shift_q, shift_d;
   logic [TW-1:0]     to_cnt_q, to_cnt_d;
   logic              accept, reject, frame_ok;
   logic [8*CODE_BYTES-1:0] code_q, code_shift;
   logic              frame_err_q, overflow_q;
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic              empty, full, pop, push, drop;

   // Filtered clock only flips after FILTER_LEN consecutive differing samples.
   always_comb begin
      filt_d    = filt_q;
      flt_cnt_d = '0;
      if (clk_s2_q != filt_q) begin
         if (flt_cnt_q == FW'(FILTER_LEN - 1))
            filt_d = clk_s2_q;
         else
            flt_cnt_d = flt_cnt_q + FW'(1);
      end
   end

   assign sample_evt = filt_q & ~filt_d;

`ifdef PS2_RX_PARITY_CHECK_EN
   assign frame_ok = dat_s2_q & (ones_q ^ par_q);
`else
   assign frame_ok = dat_s2_q;
`endif

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      ones_d    = ones_q;
      shift_d   = shift_q;
      par_d     = par_q;
      to_cnt_d  = '0;
      accept    = 1'b0;
      reject    = 1'b0;
      if (state_q != S_IDLE)
         to_cnt_d = to_cnt_q + TW'(1);
      if (sample_evt) begin
         to_cnt_d = '0;
         case (state_q)
            S_IDLE: begin
               if (!dat_s2_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = 3'd0;
                  ones_d    = 1'b0;
               end
            end
            S_DATA: begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               ones_d    = ones_q ^ dat_s2_q;
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7)
                  state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
            default: begin
               state_d = S_IDLE;
               if (frame_ok)
                  accept = 1'b1;
               else
                  reject = 1'b1;
            end
         endcase
      end else if (state_q != S_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
         state_d  = S_IDLE;
         to_cnt_d = '0;
         reject   = 1'b1;
      end
   end

   generate
      if (CODE_BYTES > 1) begin : g_shift
         assign code_shift = {code_q[8*CODE_BYTES-9:0], shift_q};
      end else begin : g_single
         assign code_shift = shift_q;
      end
   endgenerate

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = byte_ready & ~empty;
   // A same-cycle pop frees a slot, so a full FIFO can still take the byte.
   assign push  = accept & (~full | pop);
   assign drop  = accept & full & ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1_q    <= 1'b1;
         clk_s2_q    <= 1'b1;
         dat_s1_q    <= 1'b1;
         dat_s2_q    <= 1'b1;
         filt_q      <= 1'b1;
         flt_cnt_q   <= '0;
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         ones_q      <= 1'b0;
         par_q       <= 1'b0;
         shift_q     <= 8'h00;
         to_cnt_q    <= '0;
         code_q      <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         clk_s1_q    <= PS2_KBCLK;
         clk_s2_q    <= clk_s1_q;
         dat_s1_q    <= PS2_KBDAT;
         dat_s2_q    <= dat_s1_q;
         filt_q      <= filt_d;
         flt_cnt_q   <= flt_cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         ones_q      <= ones_d;
         par_q       <= par_d;
         shift_q     <= shift_d;
         to_cnt_q    <= to_cnt_d;
         frame_err_q <= reject;
         if (accept)
            code_q <= code_shift;
         if (drop)
            overflow_q <= 1'b1;
         if (push)
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
   end

   assign code_vector = code_q;
   assign byte_valid  = ~empty;
   assign byte_data   = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
   assign frame_err   = frame_err_q;
   assign overflow    = overflow_q;
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

System-clock PS/2 keyboard receiver: synchronises and deglitches the raw PS/2 clock/data lines, deframes 11-bit frames, and checks start, parity and stop bits plus an inter-bit timeout. Accepted bytes go into a parametrised scancode history vector and a first-word-fall-through FIFO with a valid/ready handshake. It sits between the keyboard pins and the scancode decoder / display logic, replacing the PS/2-clock-domain receiver.

## Interface
- `FILTER_LEN`, 8: consecutive equal samples needed to accept a PS/2 clock level change (≥2).
- `TIMEOUT_CYCLES`, 50000: `clk` cycles allowed between bit edges inside a frame (≥16).
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two, ≥2.
- `CODE_BYTES`, 2: bytes held in `code_vector` (≥1).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `PS2_KBCLK`  in  1  raw PS/2 clock (asynchronous).
- `PS2_KBDAT`  in  1  raw PS/2 data (asynchronous).
- `code_vector`  out  8*CODE_BYTES  newest byte in [7:0], older bytes shifted up.
- `byte_data`  out  8  FIFO head; 0 when empty.
- `byte_valid`  out  1  FIFO non-empty.
- `byte_ready`  in  1  consumer pops the head when `byte_valid && byte_ready`.
- `frame_err`  out  1  one-cycle pulse per rejected frame.
- `overflow`  out  1  sticky; set when a good byte is dropped on a full FIFO; cleared only by `rst`.

## Operation
- Both raw lines pass through 2-FF synchronisers. The clock filter's output level changes only after `FILTER_LEN` consecutive synchronised samples differ from it. The filter resets to 1.
- Sample event: a 1→0 transition of the filtered clock. Data is taken from the synchronised data line in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - A sample with data 0 moves to DATA and clears the bit count and one-count.
  - A sample with data 1 is ignored, with no error.
- DATA:
  - Shift the bit in LSB-first and count ones.
  - After the 8th bit, move to PARITY.
- PARITY: store the bit and move to STOP.
- STOP:
  - Accept the frame when stop = 1 and (ones + parity) is odd.
  - Otherwise pulse `frame_err` and discard the frame.
  - Always return to IDLE.
- Timeout:
  - Outside IDLE, a counter increments every cycle and clears on each sample event.
  - Reaching `TIMEOUT_CYCLES` forces IDLE, pulses `frame_err` and discards the partial byte.
- On accept:
  - `code_vector <= {code_vector[8*CODE_BYTES-9:0], byte}`; if CODE_BYTES = 1, `code_vector <= byte`.
  - The byte is pushed into the FIFO.
  - FIFO full with no pop in the same cycle: the byte is dropped, `overflow` is set, and `code_vector` still updates.
  - FIFO full with a pop in the same cycle: the push succeeds.
- FIFO:
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH.
  - Full: pointer MSBs differ and the remaining bits are equal. Empty: pointers are equal.
  - A pop while empty is ignored.

## Timing
- Reset values: `code_vector` = 0, `byte_data` = 0, `byte_valid` = 0, `frame_err` = 0, `overflow` = 0. State is IDLE, the FIFO is empty, and the timeout counter is 0.
- `rst` mid-frame aborts the frame immediately, with no `frame_err`.
- Sample event occurs `FILTER_LEN` + 2 cycles after the raw falling edge (synchroniser plus filter).
- If the stop-bit sample event is at cycle E, then at E+1:
  - `code_vector`, `byte_valid`, `byte_data` and `overflow` are updated, or `frame_err` is high for rejection.
- The timeout `frame_err` is asserted the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Pop at cycle P: `byte_data`/`byte_valid` show the next entry (or empty) at P+1.
- Simultaneous push and pop on an empty FIFO: the pop is ignored and the pushed byte appears at the head.

## Configuration
- `PS2_RX_PARITY_CHECK_EN`:
  - Defined: parity is checked as above, and a bad parity rejects the frame with `frame_err`.
  - Undefined: the parity bit is sampled and ignored, and only start, stop and timeout errors reject a frame.

## Test plan
- Frame 0x1C (data bits 0,0,1,1,1,0,0,0, parity 0, stop 1), `byte_ready` = 0 → `byte_valid` = 1, `byte_data` = 0x1C, `code_vector` = 0x001C.
- Frames 0xF0 (parity 1) then 0x1C → `code_vector` = 0xF01C, FIFO yields 0xF0 then 0x1C on two pops.
- Frame 0x1C with parity 1 (macro defined) → one `frame_err` pulse, FIFO unchanged. With the macro undefined → 0x1C accepted.
- Stop bit 1 withheld, then no edges for `TIMEOUT_CYCLES` → `frame_err` pulse, state IDLE, and the next valid 0x1C is received correctly.
- Five frames 0x01..0x05, `byte_ready` = 0, depth 4 → `overflow` = 1, FIFO holds 0x01..0x04, `code_vector` = 0x0405.
- `PS2_KBCLK` low glitch of `FILTER_LEN`−1 cycles in IDLE, and `rst` asserted after 4 data bits → no byte and no `frame_err`; all outputs at reset values.
